// File: rtl/mem_arbiter_if.sv
// Bundle between the two cache fill paths, the arbiter and unified main memory.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_arbiter_if;
   logic        i_re;
   logic [13:0] i_addr;
   logic        i_rdy;
   logic [63:0] i_rdata;
   logic        d_re;
   logic        d_we;
   logic [13:0] d_addr;
   logic [63:0] d_wdata;
   logic        d_rdy;
   logic [63:0] d_rdata;
   logic        mem_re;
   logic        mem_we;
   logic [13:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_rdy;
   logic        busy;

   modport slave (
      input  i_re, i_addr, d_re, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
      output i_rdy, i_rdata, d_rdy, d_rdata, mem_re, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output i_re, i_addr, d_re, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
      input  i_rdy, i_rdata, d_rdy, d_rdata, mem_re, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates unified main memory between I-cache fills and D-cache fills/write-backs.
// state   | meaning
// IDLE    | evaluate requests; memory strobes low
// GNT_I   | instruction read in flight, waiting for mem_rdy
// GNT_D   | data read or write-back in flight, waiting for mem_rdy
// DONE    | owner's rdy pulses; requests ignored this cycle
module mem_arbiter #(
   parameter int MAX_D_STREAK = 4
) (
   input logic        clk,
   input logic        rst_n,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GNT_I = 2'd1,
      S_GNT_D = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] L_MAX = 4'(MAX_D_STREAK);

   state_t      r_state;
   logic [3:0]  r_streak;
   logic        r_i_rdy;
   logic        r_d_rdy;
   logic [63:0] r_i_rdata;
   logic [63:0] r_d_rdata;
   logic        r_mem_re;
   logic        r_mem_we;
   logic [13:0] r_mem_addr;
   logic [63:0] r_mem_wdata;
   logic        r_busy;

   logic        w_d_req;
   logic        w_grant_d;
   logic        w_grant_i;

   assign w_d_req   = bus.d_re | bus.d_we;
   // Data wins unless the streak limit is reached while an instruction fetch waits.
   assign w_grant_d = w_d_req && ((r_streak < L_MAX) || !bus.i_re);
   assign w_grant_i = !w_grant_d && bus.i_re;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_streak    <= 4'd0;
         r_i_rdy     <= 1'b0;
         r_d_rdy     <= 1'b0;
         r_i_rdata   <= 64'd0;
         r_d_rdata   <= 64'd0;
         r_mem_re    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 14'd0;
         r_mem_wdata <= 64'd0;
         r_busy      <= 1'b0;
      end else begin
         r_i_rdy <= 1'b0;
         r_d_rdy <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_d) begin
                  r_state     <= S_GNT_D;
                  r_mem_re    <= ~bus.d_we;
                  r_mem_we    <= bus.d_we;
                  r_mem_addr  <= bus.d_addr;
                  r_mem_wdata <= bus.d_wdata;
                  r_busy      <= 1'b1;
                  if (!bus.i_re)
                     r_streak <= 4'd0;
                  else if (r_streak < L_MAX)
                     r_streak <= r_streak + 4'd1;
               end else if (w_grant_i) begin
                  r_state     <= S_GNT_I;
                  r_mem_re    <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= bus.i_addr;
                  r_mem_wdata <= 64'd0;
                  r_busy      <= 1'b1;
                  r_streak    <= 4'd0;
               end
            end
            S_GNT_I, S_GNT_D: begin
               if (bus.mem_rdy) begin
                  r_state     <= S_DONE;
                  r_mem_re    <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= 14'd0;
                  r_mem_wdata <= 64'd0;
                  if (r_state == S_GNT_D) begin
                     r_d_rdy <= 1'b1;
                     if (r_mem_re)
                        r_d_rdata <= bus.mem_rdata;
                  end else begin
                     r_i_rdy   <= 1'b1;
                     r_i_rdata <= bus.mem_rdata;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.i_rdy     = r_i_rdy;
   assign bus.i_rdata   = r_i_rdata;
   assign bus.d_rdy     = r_d_rdy;
   assign bus.d_rdata   = r_d_rdata;
   assign bus.mem_re    = r_mem_re;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random request
// traffic, compared against a transaction-level model of grant order and read data.
module tb_mem_arbiter;

   localparam int MAXS = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if bus();

   mem_arbiter #(.MAX_D_STREAK(MAXS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   int          m_streak;
   logic [63:0] m_i_rdata;
   logic [63:0] m_d_rdata;

   bit          p_i, p_dre, p_dwe;
   logic [13:0] p_iaddr, p_daddr;
   logic [63:0] p_dwdata;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_reqs();
      bus.i_re    = p_i;
      bus.i_addr  = p_iaddr;
      bus.d_re    = p_dre;
      bus.d_we    = p_dwe;
      bus.d_addr  = p_daddr;
      bus.d_wdata = p_dwdata;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"},  64'(bus.busy), 64'd0);
      chk({tag, "_re"},    64'(bus.mem_re), 64'd0);
      chk({tag, "_we"},    64'(bus.mem_we), 64'd0);
      chk({tag, "_addr"},  64'(bus.mem_addr), 64'd0);
      chk({tag, "_wdata"}, bus.mem_wdata, 64'd0);
      chk({tag, "_rdy"},   64'({bus.i_rdy, bus.d_rdy}), 64'd0);
   endtask

   // One arbitration round starting at a negedge while the arbiter is idle.
   task automatic txn(input int lat, input bit fix_rd, input logic [63:0] rd_val, output bit obs_d);
      bit          gd, gi, wr;
      logic [13:0] a;
      logic [63:0] wd, rd;
      obs_d = 1'b0;
      drive_reqs();
      gd = (p_dre || p_dwe) && ((m_streak < MAXS) || !p_i);
      gi = !gd && p_i;
      if (!gd && !gi) begin
         @(posedge clk); @(negedge clk);
         chk_quiet("norq");
         return;
      end
      wr = gd && p_dwe;
      a  = gd ? p_daddr : p_iaddr;
      wd = p_dwdata;
      if (gd) m_streak = p_i ? ((m_streak < MAXS) ? m_streak + 1 : m_streak) : 0;
      else    m_streak = 0;
      rd = fix_rd ? rd_val : {$urandom, $urandom};
      @(posedge clk); @(negedge clk);
      for (int k = 0; k <= lat; k++) begin
         chk("gnt_re",   64'(bus.mem_re), 64'(!wr));
         chk("gnt_we",   64'(bus.mem_we), 64'(wr));
         chk("gnt_addr", 64'(bus.mem_addr), 64'(a));
         if (gd) chk("gnt_wdata", bus.mem_wdata, wd);
         chk("gnt_busy", 64'(bus.busy), 64'd1);
         chk("gnt_rdy",  64'({bus.i_rdy, bus.d_rdy}), 64'd0);
         if (gd) begin
            bus.d_addr  = 14'($urandom);
            bus.d_wdata = {$urandom, $urandom};
         end else begin
            bus.i_addr = 14'($urandom);
         end
         bus.mem_rdy   = (k == lat);
         bus.mem_rdata = (k == lat) ? rd : {$urandom, $urandom};
         @(posedge clk); @(negedge clk);
      end
      bus.mem_rdy   = 1'b0;
      bus.mem_rdata = {$urandom, $urandom};
      if (!wr) begin
         if (gd) m_d_rdata = rd;
         else    m_i_rdata = rd;
      end
      obs_d = bus.d_rdy;
      chk("done_i_rdy",   64'(bus.i_rdy), 64'(gi));
      chk("done_d_rdy",   64'(bus.d_rdy), 64'(gd));
      chk("done_strobes", 64'({bus.mem_re, bus.mem_we}), 64'd0);
      chk("done_addr",    64'(bus.mem_addr), 64'd0);
      chk("done_busy",    64'(bus.busy), 64'd1);
      chk("done_i_rdata", bus.i_rdata, m_i_rdata);
      chk("done_d_rdata", bus.d_rdata, m_d_rdata);
      if (gd) begin
         p_dre = 1'b0;
         p_dwe = 1'b0;
      end else begin
         p_i = 1'b0;
      end
      drive_reqs();
      @(posedge clk); @(negedge clk);
      chk("post_busy", 64'(bus.busy), 64'd0);
      chk("post_rdy",  64'({bus.i_rdy, bus.d_rdy}), 64'd0);
      chk("post_re",   64'({bus.mem_re, bus.mem_we}), 64'd0);
   endtask

   task automatic new_reqs();
      if (!p_i && ($urandom_range(0, 1) == 1)) begin
         p_i     = 1'b1;
         p_iaddr = 14'($urandom);
      end
      if (!p_dre && !p_dwe && ($urandom_range(0, 1) == 1)) begin
         p_dwe    = 1'($urandom_range(0, 1));
         p_dre    = p_dwe ? 1'($urandom_range(0, 1)) : 1'b1;
         p_daddr  = 14'($urandom);
         p_dwdata = {$urandom, $urandom};
      end
   endtask

   initial begin
      bit od;
      p_i = 0; p_dre = 0; p_dwe = 0;
      p_iaddr = '0; p_daddr = '0; p_dwdata = '0;
      m_streak = 0; m_i_rdata = '0; m_d_rdata = '0;
      drive_reqs();
      bus.mem_rdy = 1'b0;
      bus.mem_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_quiet("rst");
      chk("rst_i_rdata", bus.i_rdata, 64'd0);
      chk("rst_d_rdata", bus.d_rdata, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Instruction read, L=3
      p_i = 1'b1; p_iaddr = 14'h0123;
      txn(3, 1'b1, 64'hDEAD_BEEF_0123_4567, od);
      chk("iread_rdata", bus.i_rdata, 64'hDEAD_BEEF_0123_4567);

      // Data read, then write-back with d_re and d_we both high
      p_dre = 1'b1; p_daddr = 14'h0456; p_dwdata = 64'h0;
      txn(0, 1'b1, 64'hCAFE_F00D_5555_AAAA, od);
      p_dre = 1'b1; p_dwe = 1'b1; p_daddr = 14'h3ABC; p_dwdata = 64'h1111_2222_3333_4444;
      txn(2, 1'b0, 64'h0, od);
      chk("wb_d_rdata_kept", bus.d_rdata, 64'hCAFE_F00D_5555_AAAA);

      // Simultaneous i_re and d_re: data first, instruction next
      p_i = 1'b1; p_iaddr = 14'h0777; p_dre = 1'b1; p_daddr = 14'h0888;
      txn(0, 1'b0, 64'h0, od);
      chk("simul_first_d", 64'(od), 64'd1);
      txn(0, 1'b0, 64'h0, od);
      chk("simul_second_i", 64'(od), 64'd0);

      // Starvation bound: both held continuously
      for (int k = 0; k < 2 * (MAXS + 1) + 1; k++) begin
         if (!p_i) begin p_i = 1'b1; p_iaddr = 14'($urandom); end
         if (!p_dre) begin p_dre = 1'b1; p_daddr = 14'($urandom); p_dwdata = {$urandom, $urandom}; end
         txn($urandom_range(0, 2), 1'b0, 64'h0, od);
         chk("starve_seq", 64'(od), 64'((k % (MAXS + 1)) != MAXS));
      end
      p_i = 1'b0; p_dre = 1'b0; p_dwe = 1'b0;
      m_streak = 0;
      drive_reqs();
      @(posedge clk); @(negedge clk);

      // Spurious mem_rdy in IDLE
      bus.mem_rdy = 1'b1;
      @(posedge clk); @(negedge clk);
      chk_quiet("spur");
      bus.mem_rdy = 1'b0;
      @(posedge clk); @(negedge clk);
      chk_quiet("spur2");

      // Random traffic
      for (int n = 0; n < 200; n++) begin
         new_reqs();
         txn($urandom_range(0, 3), 1'b0, 64'h0, od);
      end
      p_i = 1'b0; p_dre = 1'b0; p_dwe = 1'b0;
      drive_reqs();
      @(posedge clk); @(negedge clk);

      // Reset mid GNT_D with mem_we high
      p_dwe = 1'b1; p_daddr = 14'h1234; p_dwdata = 64'h9999_8888_7777_6666;
      drive_reqs();
      @(posedge clk); @(negedge clk);
      chk("rstw_we_before", 64'(bus.mem_we), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstw_we_now",   64'(bus.mem_we), 64'd0);
      chk("rstw_busy_now", 64'(bus.busy), 64'd0);
      bus.mem_rdy = 1'b1;
      repeat (2) begin
         @(posedge clk); @(negedge clk);
         chk("rstw_no_drdy", 64'(bus.d_rdy), 64'd0);
      end
      p_dwe = 1'b0;
      drive_reqs();
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.mem_rdy = 1'b0;
      chk("rstw_no_drdy_after", 64'(bus.d_rdy), 64'd0);
      chk_quiet("rstw_idle");
      chk("rstw_i_rdata", bus.i_rdata, 64'd0);
      chk("rstw_d_rdata", bus.d_rdata, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single unified main memory between the instruction-cache fill path and the data-cache fill/write-back path. It sits between the cache controllers and main memory. It accepts one request at a time, holds the memory interface stable until the memory signals completion, and returns a one-cycle ready pulse to the winning requester. Data requests normally win. A streak counter stops a run of back-to-back data requests from starving instruction fetch.

## Interface
Parameters:
- MAX_D_STREAK, default 4: consecutive data grants allowed while an instruction request waits; legal range 1..15.

Ports (clock and reset first):
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_re  in  1  instruction line read request; held until i_rdy.
- i_addr  in  14  instruction line address.
- i_rdy  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  64  registered read line for the instruction requester.
- d_re  in  1  data line read request; held until d_rdy.
- d_we  in  1  data line write (write-back) request; held until d_rdy; wins over d_re when both are high.
- d_addr  in  14  data line address.
- d_wdata  in  64  write-back line.
- d_rdy  out  1  one-cycle pulse: data transaction complete.
- d_rdata  out  64  registered read line for the data requester.
- mem_re  out  1  memory read strobe; held for the whole transaction.
- mem_we  out  1  memory write strobe; held for the whole transaction.
- mem_addr  out  14  latched line address.
- mem_wdata  out  64  latched write line.
- mem_rdata  in  64  memory read data; valid when mem_rdy is high.
- mem_rdy  in  1  memory completion strobe.
- busy  out  1  high in every state other than IDLE.

## Operation
States: IDLE, GNT_I, GNT_D, DONE.

IDLE:
- Evaluate requests.
- Data request (d_re or d_we) present and streak < MAX_D_STREAK, or no i_re: grant data.
  - Latch d_addr, d_wdata and the op (write if d_we).
  - Go to GNT_D.
- Else if i_re: grant instruction.
  - Latch i_addr; op is read.
  - Go to GNT_I.
- No request: stay in IDLE.

GNT_I / GNT_D:
- mem_addr and mem_wdata are driven from the latches.
- Exactly one of mem_re/mem_we is high, per the latched op.
- On mem_rdy:
  - For a read, capture mem_rdata into the owner's rdata register.
  - Go to DONE.
- Without mem_rdy: stay; outputs are unchanged.

DONE:
- The owner's rdy is high for this cycle only.
- Requests are ignored this cycle, so the requester may drop its request here without a re-grant.
- Next state is IDLE.

Streak counter:
- 4 bits; increments on each data grant made while i_re is high.
- Clears on an instruction grant, and on a data grant made while i_re is low.
- Saturates at MAX_D_STREAK.

Idle values: mem_re, mem_we, mem_addr and mem_wdata are 0 in IDLE and DONE.

rdata registers:
- Change only on a read completion for their own port.
- Are not modified by a write completion (d_rdata keeps its value).

## Timing
Reset values (asynchronous, immediate on rst_n low):
- state = IDLE, streak = 0.
- All outputs 0, including both rdata registers.
- Reset during GNT_x abandons the memory transaction: strobes drop in the same instant and no rdy is ever issued for it.

Latency:
- Request seen in IDLE at cycle 0; strobe high at cycle 1.
- mem_rdy at cycle 1+L (L ≥ 0); rdy pulse at cycle 2+L.
- Minimum request-to-rdy latency is 2 cycles.

Back-to-back behaviour:
- A requester that keeps its request high after DONE is re-evaluated in the following IDLE cycle.
- Throughput is therefore at most one transaction per L+3 cycles.

Other rules:
- mem_rdy outside GNT_x is ignored.
- Requester inputs changing while in GNT_x have no effect (the transaction uses the latched values).
- Simultaneous i_re and d_re in IDLE with streak < MAX_D_STREAK: data wins.
- With streak == MAX_D_STREAK: instruction wins.

## Test plan
- **Reset values.** Assert rst_n low mid-GNT_D with mem_we high -> mem_we=0, busy=0, d_rdy never pulses; after release, IDLE with all outputs 0.
- **Instruction read.** Single i_re, i_addr=14'h0123; memory returns 64'hDEAD_BEEF_0123_4567 with L=3 -> mem_re high with mem_addr=14'h0123 for 4 cycles; i_rdy pulses once at cycle 5; i_rdata = 64'hDEAD_BEEF_0123_4567.
- **Write-back.** d_we=1 and d_re=1 together, d_wdata=64'h1111_2222_3333_4444 -> mem_we=1, mem_re=0, mem_wdata matches; d_rdy pulses once; d_rdata keeps its previous value.
- **Simultaneous requests.** i_re and d_re rise in the same cycle with L=0 -> data is served first (d_rdy at cycle 2); the instruction grant follows in the next IDLE (i_rdy at cycle 5).
- **Starvation bound.** With MAX_D_STREAK=4, d_re held continuously and i_re held -> exactly 4 data grants, then an instruction grant, then data resumes; streak is back to 0 after the instruction grant.
- **Input and strobe isolation.** Change i_addr mid-transaction, and pulse mem_rdy while in IDLE -> mem_addr keeps the latched address; no state change and no rdy pulse from the spurious mem_rdy.
